iter_shift_unit: RTL and testbench
==================================

Name: iter_shift_unit

Overview:
- Multi-cycle, one-bit-per-clock shift/rotate engine for the 8-bit datapath.
- Covers the rotate direction the single-cycle unit lacks (rotate left), plus SLL, SRL, SRA and ROR.
- Driven by the control unit with a START/BUSY/DONE handshake.
- The processor stalls while BUSY is high; RESULT is written back on DONE.

Parameters:
- WIDTH, 8, operand/result width; must be a power of two, at least 4.
- CNT_W, $clog2(WIDTH)+1, width of the internal step counter (holds 0..WIDTH).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only in IDLE.
- OPCODE  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL; 101-111 invalid.
- OPERAND1  in  WIDTH  value to shift.
- SHAMT  in  6  requested shift/rotate amount.
- RESULT  out  WIDTH  final value; held until the next completion.
- BUSY  out  1  high from the START edge until the DONE cycle ends.
- DONE  out  1  one-cycle pulse; RESULT is valid in this cycle.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE; RESULT, BUSY, DONE, working register and counter all 0. Applies immediately, including mid-operation; the in-flight operation is discarded.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - If START=1 at a rising edge: latch OPERAND1 into the working register and OPCODE into the op register; load counter n; set BUSY=1.
  - Next state is SHIFT if n>0, otherwise FIN.
  - If START=0: stay in IDLE.
- Effective count n:
  - SLL/SRL/SRA: min(SHAMT, WIDTH). Amounts of WIDTH or more saturate, giving 0 for logical shifts and all sign bits for SRA.
  - ROR/ROL: SHAMT mod WIDTH.
  - Invalid opcode: 0, so the result is OPERAND1 unchanged.
- SHIFT: each edge applies one single-bit step to the working register and decrements the counter. When the counter goes 1→0, next state is FIN.
- Single-bit step rules:
  - SLL: shift in 0 at the LSB.
  - SRL: shift in 0 at the MSB.
  - SRA: replicate the MSB.
  - ROR: old LSB moves to the MSB.
  - ROL: old MSB moves to the LSB.
- FIN: on entering, RESULT is registered from the working register. DONE=1 and BUSY=1 for exactly that one cycle; next edge returns to IDLE with BUSY=0 and DONE=0.
- Latency: DONE is high in cycle n+1 after the accepting edge (n SHIFT cycles plus 1 FIN cycle). Maximum is WIDTH+1 cycles.
- START while BUSY=1 is ignored. A new START is accepted no earlier than the edge after FIN.
- OPERAND1, SHAMT and OPCODE changes after acceptance have no effect.
- RESULT is never modified outside FIN entry and reset.

Optional Feature:
- Macro: ITER_SHIFT_FLAGS_EN.
- Defined: adds two outputs, both registered on FIN entry and reset to 0:
  - CARRY (1 bit): last bit shifted or rotated out; 0 when n=0.
  - ZERO (1 bit): high when RESULT==0.
- Undefined: neither port exists; no flag logic.

Decomposition:
- Shared package shift_pkg holds:
  - opcode constants OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL;
  - the state enum (IDLE, SHIFT, FIN);
  - default WIDTH.
- One natural sub-module: shift_step, the combinational single-bit next-value function (inputs: value, opcode; outputs: next value, bit out). It is instantiated once in the SHIFT path.

Test Plan:
- SLL, OPERAND1=0x81, SHAMT=1 → DONE in cycle 2, RESULT=0x02, BUSY high for cycles 1-2; CARRY=1 if flags enabled.
- SRA, 0x90, SHAMT=3 → DONE in cycle 4, RESULT=0xF2.
- ROL, 0x96, SHAMT=11 (n=3) → DONE in cycle 4, RESULT=0xB4.
- SRL, 0xFF, SHAMT=40 (n saturates to 8) → DONE in cycle 9, RESULT=0x00; flags: CARRY=1, ZERO=1.
- ROR, 0x5A, SHAMT=0 → DONE in cycle 1, RESULT=0x5A. A second START pulsed during BUSY is ignored: exactly one DONE pulse.
- SLL, 0x01, SHAMT=7, RESET driven low in cycle 3 → immediately BUSY=0, DONE=0, RESULT=0x00. After release, SLL 0x01 by 7 gives RESULT=0x80 in cycle 8.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift/rotate engine.
// Opcodes, FSM states and the default datapath width.
package shift_pkg;

   localparam int DEF_WIDTH = 8;

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FIN
   } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step: next value and the bit pushed out.
// Unknown opcodes pass the value through with a zero bit out.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] value,
   input  logic [2:0]       opcode,
   output logic [WIDTH-1:0] next_value,
   output logic             bit_out
);

   // one-position move selected by opcode
   always_comb begin
      next_value = value;
      bit_out    = 1'b0;
      case (opcode)
         OP_SLL: begin
            next_value = {value[WIDTH-2:0], 1'b0};
            bit_out    = value[WIDTH-1];
         end
         OP_SRL: begin
            next_value = {1'b0, value[WIDTH-1:1]};
            bit_out    = value[0];
         end
         OP_SRA: begin
            next_value = {value[WIDTH-1], value[WIDTH-1:1]};
            bit_out    = value[0];
         end
         OP_ROR: begin
            next_value = {value[0], value[WIDTH-1:1]};
            bit_out    = value[0];
         end
         OP_ROL: begin
            next_value = {value[WIDTH-2:0], value[WIDTH-1]};
            bit_out    = value[WIDTH-1];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/iter_shift_unit.sv
// One-bit-per-clock shift/rotate engine with START/BUSY/DONE handshake.
// Define ITER_SHIFT_FLAGS_EN to add registered CARRY and ZERO outputs.
module iter_shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [2:0]       OPCODE,
   input  logic [WIDTH-1:0] OPERAND1,
   input  logic [5:0]       SHAMT,
   output logic [WIDTH-1:0] RESULT,
   output logic             BUSY,
   output logic             DONE
`ifdef ITER_SHIFT_FLAGS_EN
   ,
   output logic             CARRY,
   output logic             ZERO
`endif
);

   localparam int LW = $clog2(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   work;
   logic [2:0]         op;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   n;
   logic [WIDTH-1:0]   step_val;
   logic               step_out;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .value      (work),
      .opcode     (op),
      .next_value (step_val),
      .bit_out    (step_out)
   );

   // effective step count: shifts saturate, rotates wrap, invalid is 0
   always_comb begin
      n = '0;
      case (OPCODE)
         OP_SLL, OP_SRL, OP_SRA: begin
            if (int'(SHAMT) >= WIDTH)
               n = CNT_W'(WIDTH);
            else
               n = CNT_W'(SHAMT);
         end
         OP_ROR, OP_ROL: n = CNT_W'(SHAMT[LW-1:0]);
         default: n = '0;
      endcase
   end

   // state register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (START)
               state_nxt = (n != '0) ? SHIFT : FIN;
         end
         SHIFT: begin
            if (cnt == CNT_W'(1))
               state_nxt = FIN;
         end
         FIN: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign BUSY = (state != IDLE);
   assign DONE = (state == FIN);

   // operand capture, stepping, and result capture on FIN entry
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         work   <= '0;
         op     <= '0;
         cnt    <= '0;
         RESULT <= '0;
`ifdef ITER_SHIFT_FLAGS_EN
         CARRY  <= 1'b0;
         ZERO   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  work <= OPERAND1;
                  op   <= OPCODE;
                  cnt  <= n;
                  if (n == '0) begin
                     RESULT <= OPERAND1;
`ifdef ITER_SHIFT_FLAGS_EN
                     CARRY  <= 1'b0;
                     ZERO   <= (OPERAND1 == '0);
`endif
                  end
               end
            end
            SHIFT: begin
               work <= step_val;
               cnt  <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  RESULT <= step_val;
`ifdef ITER_SHIFT_FLAGS_EN
                  CARRY  <= step_out;
                  ZERO   <= (step_val == '0);
`endif
               end
            end
            default: ;
         endcase
      end
   end

`ifndef ITER_SHIFT_FLAGS_EN
   logic unused_bit;
   assign unused_bit = step_out;
`endif

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit with hand-computed vectors.
// Flag outputs are checked when ITER_SHIFT_FLAGS_EN is defined.
module tb_iter_shift_unit;
   import shift_pkg::*;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       START = 1'b0;
   logic [2:0] OPCODE = 3'b000;
   logic [7:0] OPERAND1 = 8'h00;
   logic [5:0] SHAMT = 6'd0;
   logic [7:0] RESULT;
   logic       BUSY;
   logic       DONE;
`ifdef ITER_SHIFT_FLAGS_EN
   logic       CARRY;
   logic       ZERO;
`endif

   int n_chk = 0;
   int n_fail = 0;

   iter_shift_unit #(
      .WIDTH (8)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .OPCODE   (OPCODE),
      .OPERAND1 (OPERAND1),
      .SHAMT    (SHAMT),
      .RESULT   (RESULT),
      .BUSY     (BUSY),
      .DONE     (DONE)
`ifdef ITER_SHIFT_FLAGS_EN
      ,
      .CARRY    (CARRY),
      .ZERO     (ZERO)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] opc,
                         input logic [7:0] a, input logic [5:0] sh,
                         input logic [7:0] exp, input int lat,
                         input logic exp_c, input logic exp_z);
      int cyc;
      int busy_bad;
      @(negedge CLK);
      OPCODE = opc;
      OPERAND1 = a;
      SHAMT = sh;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      OPERAND1 = ~a;
      SHAMT = 6'd5;
      OPCODE = OP_SLL;
      cyc = 1;
      busy_bad = 0;
      while (!DONE && cyc < 20) begin
         if (!BUSY) busy_bad++;
         @(posedge CLK);
         #1;
         cyc++;
      end
      if (!BUSY) busy_bad++;
      check({tag, " latency"}, cyc, lat);
      check({tag, " busy"}, busy_bad, 0);
      check({tag, " result"}, RESULT, exp);
`ifdef ITER_SHIFT_FLAGS_EN
      check({tag, " carry"}, CARRY, exp_c);
      check({tag, " zero"}, ZERO, exp_z);
`else
      if (exp_c === 1'bx || exp_z === 1'bx)
         $display("note: %s flag expectation unknown", tag);
`endif
      @(posedge CLK);
      #1;
      check({tag, " idle"}, {BUSY, DONE}, 2'b00);
      check({tag, " hold"}, RESULT, exp);
   endtask

   initial begin
      int dones;
      #12;
      check("rst busy", BUSY, 1'b0);
      check("rst done", DONE, 1'b0);
      check("rst result", RESULT, 8'h00);
      @(negedge CLK);
      RESET = 1'b1;

      run_op("sll1", OP_SLL, 8'h81, 6'd1, 8'h02, 2, 1'b1, 1'b0);
      run_op("sra3", OP_SRA, 8'h90, 6'd3, 8'hF2, 4, 1'b0, 1'b0);
      run_op("rol11", OP_ROL, 8'h96, 6'd11, 8'hB4, 4, 1'b0, 1'b0);
      run_op("srl40", OP_SRL, 8'hFF, 6'd40, 8'h00, 9, 1'b1, 1'b1);
      run_op("sll8", OP_SLL, 8'hFF, 6'd8, 8'h00, 9, 1'b1, 1'b1);
      run_op("sra63", OP_SRA, 8'h80, 6'd63, 8'hFF, 9, 1'b1, 1'b0);
      run_op("ror8", OP_ROR, 8'h3C, 6'd8, 8'h3C, 1, 1'b0, 1'b0);
      run_op("inval", 3'b101, 8'hA7, 6'd5, 8'hA7, 1, 1'b0, 1'b0);
      run_op("ror1", OP_ROR, 8'h01, 6'd1, 8'h80, 2, 1'b1, 1'b0);

      // ROR by 0 with a second START held through the FIN cycle
      @(negedge CLK);
      OPCODE = OP_ROR;
      OPERAND1 = 8'h5A;
      SHAMT = 6'd0;
      START = 1'b1;
      @(posedge CLK);
      #1;
      check("ror0 done", DONE, 1'b1);
      check("ror0 busy", BUSY, 1'b1);
      check("ror0 result", RESULT, 8'h5A);
      OPCODE = OP_SLL;
      OPERAND1 = 8'h01;
      SHAMT = 6'd3;
      @(posedge CLK);
      #1;
      START = 1'b0;
      check("ror0 idle", {BUSY, DONE}, 2'b00);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK);
         #1;
         if (DONE) dones++;
      end
      check("ror0 extra done", dones, 0);
      check("ror0 hold", RESULT, 8'h5A);

      // asynchronous reset in the middle of an operation
      @(negedge CLK);
      OPCODE = OP_SLL;
      OPERAND1 = 8'h01;
      SHAMT = 6'd7;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      check("mid busy pre", BUSY, 1'b1);
      RESET = 1'b0;
      #1;
      check("mid rst busy", BUSY, 1'b0);
      check("mid rst done", DONE, 1'b0);
      check("mid rst result", RESULT, 8'h00);
      @(negedge CLK);
      RESET = 1'b1;
      run_op("sll7", OP_SLL, 8'h01, 6'd7, 8'h80, 8, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
